// File: rtl/ex_stage_mdu.sv
// Execute stage: single-cycle ALU, branch target adder, and a multicycle
// multiply/divide unit that owns HI/LO. All results leave through a
// single registered output with a valid/ready handshake.
module ex_stage_mdu #(
    parameter int WIDTH      = 32,
    parameter int PC_WIDTH   = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [WIDTH-1:0]         read_rs,
    input  logic [WIDTH-1:0]         read_rt,
    input  logic [WIDTH-1:0]         sign_ext,
    input  logic [$clog2(WIDTH)-1:0] sa,
    input  logic [5:0]               funct,
    input  logic [1:0]               alu_op,
    input  logic                     alu_src,
    input  logic                     flag_branch,
    input  logic [PC_WIDTH-1:0]      post_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_alu,
    output logic                     zero_alu,
    output logic [PC_WIDTH-1:0]      out_add_ex,
    output logic                     busy
);

    localparam int SHW     = $clog2(WIDTH);
    localparam int EXT_W   = (WIDTH > PC_WIDTH) ? WIDTH : PC_WIDTH;
    localparam int CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_SLLV  = 6'h04;
    localparam logic [5:0] F_SRLV  = 6'h06;
    localparam logic [5:0] F_SRAV  = 6'h07;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [WIDTH-1:0]    hi_q;
    logic [WIDTH-1:0]    lo_q;
    logic [WIDTH-1:0]    opA_q;
    logic [WIDTH-1:0]    opB_q;
    logic                isSigned_q;
    logic                flag_q;
    logic [PC_WIDTH-1:0] target_q;
    logic [WIDTH-1:0]    quo_q;
    logic [WIDTH-1:0]    rem_q;
    logic [WIDTH-1:0]    dsr_q;
    logic                outValid_q;
    logic [WIDTH-1:0]    outAlu_q;
    logic                zero_q;
    logic [PC_WIDTH-1:0] outAdd_q;

    logic [WIDTH-1:0]    opB;
    logic [SHW-1:0]      shVar;
    logic [EXT_W-1:0]    immExt;
    logic [PC_WIDTH-1:0] branchTarget;
    logic                canLoad;
    logic                accept;
    logic                isMul;
    logic                isDiv;
    logic                divSignedIn;
    logic [WIDTH-1:0]    absA;
    logic [WIDTH-1:0]    absB;
    logic [WIDTH-1:0]    aluResult_d;

    logic [2*WIDTH-1:0]  extA;
    logic [2*WIDTH-1:0]  extB;
    logic [2*WIDTH-1:0]  product;

    logic [WIDTH:0]      remShift;
    logic                remGe;
    logic [WIDTH-1:0]    stepRem_d;
    logic [WIDTH-1:0]    stepQuo_d;
    logic                lastStep;
    logic [WIDTH-1:0]    finQuo;
    logic [WIDTH-1:0]    finRem;
    logic                negQ;
    logic                negR;
    logic                divZero;
    logic [WIDTH-1:0]    divLo;
    logic [WIDTH-1:0]    divHi;

    // Operand select, branch target and handshake qualifiers.
    assign opB          = alu_src ? sign_ext : read_rt;
    assign shVar        = opB[SHW-1:0];
    assign immExt       = EXT_W'($signed(sign_ext));
    assign branchTarget = post_pc + PC_WIDTH'(immExt << 2);
    assign canLoad      = !outValid_q || out_ready;
    assign in_ready     = (state_q == S_IDLE) && canLoad;
    assign accept       = in_valid && in_ready;
    assign busy         = (state_q != S_IDLE);

    assign isMul       = (alu_op == 2'b10) && ((funct == F_MULT) || (funct == F_MULTU));
    assign isDiv       = (alu_op == 2'b10) && ((funct == F_DIV) || (funct == F_DIVU));
    assign divSignedIn = (funct == F_DIV);
    assign absA        = (divSignedIn && read_rs[WIDTH-1]) ? (~read_rs + 1'b1) : read_rs;
    assign absB        = (divSignedIn && opB[WIDTH-1]) ? (~opB + 1'b1) : opB;

    assign out_valid  = outValid_q;
    assign out_alu    = outAlu_q;
    assign zero_alu   = zero_q;
    assign out_add_ex = outAdd_q;

    // Single-cycle ALU result for the op currently presented at the input.
    always_comb begin
        aluResult_d = '0;
        case (alu_op)
            2'b00: aluResult_d = read_rs + opB;
            2'b01: aluResult_d = read_rs - opB;
            2'b11: aluResult_d = read_rs | opB;
            default: begin
                case (funct)
                    F_ADD, F_ADDU: aluResult_d = read_rs + opB;
                    F_SUB, F_SUBU: aluResult_d = read_rs - opB;
                    F_AND:         aluResult_d = read_rs & opB;
                    F_OR:          aluResult_d = read_rs | opB;
                    F_XOR:         aluResult_d = read_rs ^ opB;
                    F_NOR:         aluResult_d = ~(read_rs | opB);
                    F_SLT:         aluResult_d = {{(WIDTH-1){1'b0}}, ($signed(read_rs) < $signed(opB))};
                    F_SLTU:        aluResult_d = {{(WIDTH-1){1'b0}}, (read_rs < opB)};
                    F_SLL:         aluResult_d = opB << sa;
                    F_SRL:         aluResult_d = opB >> sa;
                    F_SRA:         aluResult_d = $unsigned($signed(opB) >>> sa);
                    F_SLLV:        aluResult_d = read_rs << shVar;
                    F_SRLV:        aluResult_d = read_rs >> shVar;
                    F_SRAV:        aluResult_d = $unsigned($signed(read_rs) >>> shVar);
                    F_MFHI:        aluResult_d = hi_q;
                    F_MFLO:        aluResult_d = lo_q;
                    default:       aluResult_d = '0;
                endcase
            end
        endcase
    end

    // Multiply: operands are widened to 2*WIDTH with sign or zero fill so a
    // plain unsigned product yields the correct signed or unsigned result.
    always_comb begin
        extA    = isSigned_q ? {{WIDTH{opA_q[WIDTH-1]}}, opA_q} : {{WIDTH{1'b0}}, opA_q};
        extB    = isSigned_q ? {{WIDTH{opB_q[WIDTH-1]}}, opB_q} : {{WIDTH{1'b0}}, opB_q};
        product = extA * extB;
    end

    // One restoring-division step on magnitudes, plus the sign and
    // divide-by-zero fix-up of the final quotient and remainder. On the last
    // counted step the fresh step result is used so completion needs no
    // extra cycle; after a stall the registered values are used.
    always_comb begin
        remShift  = {rem_q, quo_q[WIDTH-1]};
        remGe     = (remShift >= {1'b0, dsr_q});
        stepRem_d = remGe ? WIDTH'(remShift - {1'b0, dsr_q}) : remShift[WIDTH-1:0];
        stepQuo_d = {quo_q[WIDTH-2:0], remGe};
        lastStep  = (cnt_q <= CNT_W'(1));
        finQuo    = (cnt_q == CNT_W'(1)) ? stepQuo_d : quo_q;
        finRem    = (cnt_q == CNT_W'(1)) ? stepRem_d : rem_q;
        negQ      = isSigned_q && (opA_q[WIDTH-1] ^ opB_q[WIDTH-1]);
        negR      = isSigned_q && opA_q[WIDTH-1];
        divZero   = (opB_q == '0);
        if (divZero) begin
            divLo = '1;
            divHi = opA_q;
        end else begin
            divLo = negQ ? (~finQuo + 1'b1) : finQuo;
            divHi = negR ? (~finRem + 1'b1) : finRem;
        end
    end

    // Control FSM with registered output, HI/LO and mul/div working state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            opA_q      <= '0;
            opB_q      <= '0;
            isSigned_q <= 1'b0;
            flag_q     <= 1'b0;
            target_q   <= '0;
            quo_q      <= '0;
            rem_q      <= '0;
            dsr_q      <= '0;
            outValid_q <= 1'b0;
            outAlu_q   <= '0;
            zero_q     <= 1'b0;
            outAdd_q   <= '0;
        end else begin
            if (outValid_q && out_ready) begin
                outValid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        if (isMul) begin
                            state_q    <= S_MUL;
                            cnt_q      <= CNT_W'(MUL_CYCLES);
                            opA_q      <= read_rs;
                            opB_q      <= opB;
                            isSigned_q <= (funct == F_MULT);
                            flag_q     <= flag_branch;
                            target_q   <= branchTarget;
                        end else if (isDiv) begin
                            state_q    <= S_DIV;
                            cnt_q      <= CNT_W'(WIDTH);
                            opA_q      <= read_rs;
                            opB_q      <= opB;
                            isSigned_q <= divSignedIn;
                            flag_q     <= flag_branch;
                            target_q   <= branchTarget;
                            quo_q      <= absA;
                            dsr_q      <= absB;
                            rem_q      <= '0;
                        end else begin
                            outValid_q <= 1'b1;
                            outAlu_q   <= aluResult_d;
                            zero_q     <= (aluResult_d == '0) ^ flag_branch;
                            outAdd_q   <= branchTarget;
                        end
                    end
                end
                S_MUL: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    if (lastStep && canLoad) begin
                        {hi_q, lo_q} <= product;
                        outValid_q   <= 1'b1;
                        outAlu_q     <= '0;
                        zero_q       <= ~flag_q;
                        outAdd_q     <= target_q;
                        cnt_q        <= '0;
                        state_q      <= S_IDLE;
                    end
                end
                S_DIV: begin
                    if (cnt_q != '0) begin
                        quo_q <= stepQuo_d;
                        rem_q <= stepRem_d;
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                    if (lastStep && canLoad) begin
                        lo_q       <= divLo;
                        hi_q       <= divHi;
                        outValid_q <= 1'b1;
                        outAlu_q   <= '0;
                        zero_q     <= ~flag_q;
                        outAdd_q   <= target_q;
                        cnt_q      <= '0;
                        state_q    <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule
